// File: rtl/chain_constraint_sweep.sv
// Gauss-Seidel sweep sequencer over a chain of 2-D points.
// Owns the position file and feeds up/centre/down neighbours to an external constraint stage.
module chain_constraint_sweep #(
  parameter int N_POINTS = 8,
  parameter int IDX_W    = 3,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [31:0]       wr_x,
  input  logic [31:0]       wr_y,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [31:0]       rd_x,
  output logic [31:0]       rd_y,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              done,
  output logic [31:0]       ec_up_x,
  output logic [31:0]       ec_up_y,
  output logic [31:0]       ec_x,
  output logic [31:0]       ec_y,
  output logic [31:0]       ec_down_x,
  output logic [31:0]       ec_down_y,
  output logic              ec_is_last,
  input  logic [31:0]       ec_x_new,
  input  logic [31:0]       ec_y_new
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);
  localparam logic [ITER_W-1:0] ONE_ITER  = ITER_W'(1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [31:0]        pos_x_q [N_POINTS];
  logic [31:0]        pos_y_q [N_POINTS];

  logic [31:0]        rd_x_q, rd_y_q;
  logic [31:0]        ec_up_x_q, ec_up_y_q, ec_x_q, ec_y_q, ec_down_x_q, ec_down_y_q;
  logic               ec_is_last_q;

  logic               load_ec;
  logic               cap_we;
  logic               wr_fire;
  logic               wr_in_range;
  logic               rd_in_range;

  logic [IDX_W-1:0]   up_sel, dn_sel;
  logic [31:0]        up_x_d, up_y_d, c_x_d, c_y_d, dn_x_d, dn_y_d;

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    load_ec = 1'b0;
    cap_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_iter != '0) begin
            iter_d  = num_iter;
            idx_d   = ONE_IDX;
            load_ec = 1'b1;
            state_d = S_PRESENT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PRESENT: begin
        busy    = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy   = 1'b1;
        cap_we = 1'b1;
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + ONE_IDX;
          load_ec = 1'b1;
          state_d = S_PRESENT;
        end else if (iter_q > ONE_ITER) begin
          iter_d  = iter_q - ONE_ITER;
          idx_d   = ONE_IDX;
          load_ec = 1'b1;
          state_d = S_PRESENT;
        end else begin
          iter_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The ec registers are loaded on the edge that enters PRESENT, which is also the edge
  // that writes back the previous point; forward that word so the sweep sees fresh data.
  always_comb begin
    up_sel = idx_d - ONE_IDX;
    dn_sel = (idx_d != LAST_IDX) ? (idx_d + ONE_IDX) : idx_d;

    up_x_d = pos_x_q[up_sel];
    up_y_d = pos_y_q[up_sel];
    c_x_d  = pos_x_q[idx_d];
    c_y_d  = pos_y_q[idx_d];
    dn_x_d = pos_x_q[dn_sel];
    dn_y_d = pos_y_q[dn_sel];

    if (cap_we && (up_sel == idx_q)) begin
      up_x_d = ec_x_new;
      up_y_d = ec_y_new;
    end
    if (cap_we && (idx_d == idx_q)) begin
      c_x_d = ec_x_new;
      c_y_d = ec_y_new;
    end
    if (cap_we && (dn_sel == idx_q)) begin
      dn_x_d = ec_x_new;
      dn_y_d = ec_y_new;
    end
  end

  assign wr_fire     = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wr_in_range = (32'(wr_idx) < 32'(N_POINTS));
  assign rd_in_range = (32'(rd_idx) < 32'(N_POINTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= ONE_IDX;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
    end
  end

  // Position file: sweep write-back and external load never occur in the same state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
      end
    end else begin
      if (cap_we) begin
        pos_x_q[idx_q] <= ec_x_new;
        pos_y_q[idx_q] <= ec_y_new;
      end
      if (wr_fire && wr_in_range) begin
        pos_x_q[wr_idx] <= wr_x;
        pos_y_q[wr_idx] <= wr_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else if (rd_in_range) begin
      rd_x_q <= pos_x_q[rd_idx];
      rd_y_q <= pos_y_q[rd_idx];
    end else begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end
  end

  // Neighbour registers hold between presentations, including through IDLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ec_up_x_q    <= '0;
      ec_up_y_q    <= '0;
      ec_x_q       <= '0;
      ec_y_q       <= '0;
      ec_down_x_q  <= '0;
      ec_down_y_q  <= '0;
      ec_is_last_q <= 1'b0;
    end else if (load_ec) begin
      ec_up_x_q    <= up_x_d;
      ec_up_y_q    <= up_y_d;
      ec_x_q       <= c_x_d;
      ec_y_q       <= c_y_d;
      ec_down_x_q  <= dn_x_d;
      ec_down_y_q  <= dn_y_d;
      ec_is_last_q <= (idx_d == LAST_IDX);
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign ec_up_x    = ec_up_x_q;
  assign ec_up_y    = ec_up_y_q;
  assign ec_x       = ec_x_q;
  assign ec_y       = ec_y_q;
  assign ec_down_x  = ec_down_x_q;
  assign ec_down_y  = ec_down_y_q;
  assign ec_is_last = ec_is_last_q;

endmodule

// File: tb/tb_chain_constraint_sweep.sv
// Directed/randomised bench for chain_constraint_sweep with an array-based sweep model.
module tb_chain_constraint_sweep;
  localparam int NP  = 8;
  localparam int IW  = 3;
  localparam int ITW = 4;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wr_en = 1'b0;
  logic [IW-1:0]  wr_idx = '0;
  logic [31:0]    wr_x = '0, wr_y = '0;
  logic [IW-1:0]  rd_idx = '0;
  logic [31:0]    rd_x, rd_y;
  logic           start = 1'b0;
  logic [ITW-1:0] num_iter = '0;
  logic           busy, done;
  logic [31:0]    ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y;
  logic           ec_is_last;
  logic [31:0]    ec_x_new, ec_y_new;

  int mode = 0;
  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mx [NP];
  logic [31:0] my [NP];
  logic [63:0] q_up[$], q_c[$], q_dn[$];
  logic        q_last[$];

  chain_constraint_sweep #(.N_POINTS(NP), .IDX_W(IW), .ITER_W(ITW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .start(start), .num_iter(num_iter),
    .busy(busy), .done(done), .ec_up_x(ec_up_x), .ec_up_y(ec_up_y), .ec_x(ec_x), .ec_y(ec_y),
    .ec_down_x(ec_down_x), .ec_down_y(ec_down_y), .ec_is_last(ec_is_last),
    .ec_x_new(ec_x_new), .ec_y_new(ec_y_new)
  );

  always #5 clk = ~clk;

  // Stand-in constraint stage; mode picks the rule.
  function automatic logic [63:0] env(int m, logic [31:0] ux, logic [31:0] uy,
                                      logic [31:0] cx, logic [31:0] cy,
                                      logic [31:0] dx, logic [31:0] dy);
    case (m)
      0:       return {cx + ONE, cy + ONE};
      1:       return {ux, uy};
      default: return {ux + (dx >> 1) - cx, (uy ^ dy) + 32'h100};
    endcase
  endfunction

  always_comb {ec_x_new, ec_y_new} = env(mode, ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y);

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, ".busy"}, {63'd0, busy}, 64'd0);
    check({tag, ".done"}, {63'd0, done}, 64'd0);
    check({tag, ".rd"}, {rd_x, rd_y}, 64'd0);
    check({tag, ".ec_up"}, {ec_up_x, ec_up_y}, 64'd0);
    check({tag, ".ec_c"}, {ec_x, ec_y}, 64'd0);
    check({tag, ".ec_dn"}, {ec_down_x, ec_down_y}, 64'd0);
    check({tag, ".is_last"}, {63'd0, ec_is_last}, 64'd0);
  endtask

  task automatic load(int i, logic [31:0] x, logic [31:0] y);
    wr_en = 1'b1; wr_idx = IW'(i); wr_x = x; wr_y = y;
    step();
    wr_en = 1'b0;
    mx[i] = x; my[i] = y;
  endtask

  task automatic readback(string tag);
    for (int i = 0; i < NP; i++) begin
      rd_idx = IW'(i);
      step();
      check($sformatf("%s.pos%0d", tag, i), {rd_x, rd_y}, {mx[i], my[i]});
    end
  endtask

  // Sweep model: plain in-place relaxation over the arrays, recording each presentation.
  task automatic model_run(int k);
    logic [63:0] up, c, dn, nw;
    q_up.delete(); q_c.delete(); q_dn.delete(); q_last.delete();
    for (int s = 0; s < k; s++) begin
      for (int i = 1; i < NP; i++) begin
        up = {mx[i-1], my[i-1]};
        c  = {mx[i], my[i]};
        dn = (i < NP - 1) ? {mx[i+1], my[i+1]} : c;
        q_up.push_back(up); q_c.push_back(c); q_dn.push_back(dn);
        q_last.push_back(i == NP - 1);
        nw = env(mode, up[63:32], up[31:0], c[63:32], c[31:0], dn[63:32], dn[31:0]);
        mx[i] = nw[63:32]; my[i] = nw[31:0];
      end
    end
  endtask

  task automatic run(string tag, int k, bit inject);
    int total;
    int j;
    model_run(k);
    total = 2 * (NP - 1) * k;
    start = 1'b1; num_iter = ITW'(k);
    step();
    start = 1'b0; num_iter = '0;
    for (int c = 1; c <= total + 2; c++) begin
      check($sformatf("%s.busy@%0d", tag, c), {63'd0, busy}, {63'd0, c <= total});
      check($sformatf("%s.done@%0d", tag, c), {63'd0, done}, {63'd0, c == total + 1});
      if (c <= total) begin
        j = (c - 1) / 2;
        check($sformatf("%s.up@%0d", tag, c), {ec_up_x, ec_up_y}, q_up[j]);
        check($sformatf("%s.c@%0d", tag, c), {ec_x, ec_y}, q_c[j]);
        check($sformatf("%s.dn@%0d", tag, c), {ec_down_x, ec_down_y}, q_dn[j]);
        check($sformatf("%s.last@%0d", tag, c), {63'd0, ec_is_last}, {63'd0, q_last[j]});
      end else if (c == total + 1 && k > 0) begin
        check($sformatf("%s.hold", tag), {ec_x, ec_y}, q_c[q_c.size() - 1]);
      end
      if (inject && c == 3) begin
        wr_en = 1'b1; wr_idx = IW'(2); wr_x = 32'hDEAD_BEEF; wr_y = 32'hCAFE_F00D;
        start = 1'b1; num_iter = ITW'(5);
      end
      if (inject && c == 4) begin
        wr_en = 1'b0; start = 1'b0; num_iter = '0;
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin mx[i] = '0; my[i] = '0; end

    #1 rst_n = 1'b0;
    #2;
    check_all_zero("por");
    step();
    #2 rst_n = 1'b1;
    step();
    readback("por_rd");

    // Basic iteration count with centre + 1.0.
    mode = 0;
    for (int i = 0; i < NP; i++) load(i, ONE * i, ONE * i);
    run("basic", 2, 1'b0);
    readback("basic_rd");
    check("basic.pos1_abs", {mx[1], my[1]}, {32'h0003_0000, 32'h0003_0000});

    // Gauss-Seidel propagation of the anchor along the chain in one sweep.
    mode = 1;
    load(0, 32'h0005_0000, 32'h0005_0000);
    for (int i = 1; i < NP; i++) load(i, '0, '0);
    run("gs", 1, 1'b0);
    readback("gs_rd");

    run("zero", 0, 1'b0);
    readback("zero_rd");

    // Busy-time write and restart must both be dropped.
    mode = 2;
    for (int i = 0; i < NP; i++) load(i, $urandom, $urandom);
    run("inject", 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("inject.nodone%0d", c), {63'd0, done}, 64'd0);
      check($sformatf("inject.idle%0d", c), {63'd0, busy}, 64'd0);
      step();
    end
    readback("inject_rd");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NP; i++) load(i, $urandom, $urandom);
      run($sformatf("rand%0d", r), int'($urandom_range(1, 3)), 1'b0);
      readback($sformatf("rand%0d_rd", r));
    end

    // Reset asserted in cycle 5 of a run.
    mode = 0;
    for (int i = 0; i < NP; i++) load(i, ONE * (i + 3), ONE * (i + 7));
    start = 1'b1; num_iter = ITW'(2);
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    check("midrst.busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < NP; i++) begin mx[i] = '0; my[i] = '0; end
    step();
    #2 rst_n = 1'b1;
    step();
    readback("midrst_rd");
    for (int i = 0; i < NP; i++) load(i, ONE * i, ONE * (NP - i));
    run("after_rst", 1, 1'b0);
    readback("after_rst_rd");

    // Same-cycle write and read of the last point.
    load(NP - 1, 32'h1111_2222, 32'h3333_4444);
    rd_idx = IW'(NP - 1);
    step();
    wr_en = 1'b1; wr_idx = IW'(NP - 1); wr_x = 32'hAAAA_5555; wr_y = 32'h5555_AAAA;
    step();
    wr_en = 1'b0;
    check("rdport.old", {rd_x, rd_y}, {32'h1111_2222, 32'h3333_4444});
    step();
    check("rdport.new", {rd_x, rd_y}, {32'hAAAA_5555, 32'h5555_AAAA});
    mx[NP-1] = 32'hAAAA_5555; my[NP-1] = 32'h5555_AAAA;
    readback("final_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chain_constraint_sweep.md
# chain_constraint_sweep

Sequencer that stores the positions of all points in a chain and runs Gauss-Seidel constraint-relaxation sweeps over them. For each point it drives the up, centre and down neighbour positions into the combinational constraint-enforcement stage, then writes the returned position back in place. The first point, index 0, is the anchor and is never written by a sweep. The block sits between the integration/load logic upstream and the renderer/readout downstream. It owns the position register file that the constraint stage reads from and writes back to.

## Interface
- `N_POINTS`, 8: number of chain points (≥2).
- `IDX_W`, 3: index width, equal to ceil(log2(N_POINTS)).
- `ITER_W`, 4: width of the iteration count.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  load strobe; honoured only when not busy.
- `wr_idx`  in  IDX_W  load index.
- `wr_x`, `wr_y`  in  32  load position.
- `rd_idx`  in  IDX_W  read index.
- `rd_x`, `rd_y`  out  32  registered read data.
- `start`  in  1  starts a run; honoured only in IDLE.
- `num_iter`  in  ITER_W  number of sweeps, sampled together with `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `ec_up_x`, `ec_up_y`, `ec_x`, `ec_y`, `ec_down_x`, `ec_down_y`  out  32  neighbour positions driven to the constraint stage.
- `ec_is_last`  out  1  high when the centre point is index N_POINTS-1.
- `ec_x_new`, `ec_y_new`  in  32  constrained position returned by the stage.

## Operation
- Data words are 32-bit fixed point in the codebase format, 1.0 = 0x00010000. The block does no arithmetic on them; it only stores and moves words.
- States: IDLE, PRESENT, CAPTURE, DONE.
- **IDLE:**
  - `start`=1 with `num_iter`≠0: latch `num_iter`, set idx=1, go to PRESENT.
  - `start`=1 with `num_iter`=0: go to DONE.
- **PRESENT:** register the ec outputs from the file.
  - up = pos[idx-1], centre = pos[idx].
  - down = pos[idx+1] when idx<N_POINTS-1; otherwise down = pos[idx].
  - `ec_is_last` = (idx==N_POINTS-1).
  - Go to CAPTURE.
- **CAPTURE:** pos[idx] <= {`ec_x_new`, `ec_y_new`}.
  - If idx<N_POINTS-1: idx+1, go to PRESENT.
  - Else if iterations remain: decrement the count, idx=1, go to PRESENT.
  - Else: go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- Write-back is in place, so point i is presented with the already-updated pos[i-1] from the same sweep.
- `busy`=1 in PRESENT and CAPTURE only; 0 in IDLE and DONE.
- `wr_en` in IDLE or DONE writes pos[`wr_idx`]. `wr_en` while busy is dropped.
- `start` outside IDLE is ignored.
- `rd_x`/`rd_y` <= pos[`rd_idx`] every cycle, including while busy.
- **Reset (at any time, including mid-run):** all pos = 0, state = IDLE, idx = 1, iteration count = 0. All outputs are 0: `busy`, `done`, `rd_*`, every `ec_*`, `ec_is_last`.

## Timing
- `start` is sampled at edge E0. PRESENT for point 1 is the cycle after E0; the ec outputs are valid from that cycle.
- The ec outputs are stable for two full cycles (PRESENT and CAPTURE). The constraint stage therefore gets a full cycle of combinational settling before capture at the end of CAPTURE.
- Each point takes 2 cycles; one sweep takes 2·(N_POINTS-1) cycles.
- With num_iter = K: `busy` is high in cycles 1 … 2·(N_POINTS-1)·K after E0. `done` is high in cycle 2·(N_POINTS-1)·K+1, and the block is in IDLE the cycle after.
- With K=0: `done` is high in cycle 1 and `busy` never asserts.
- The ec outputs hold their last values in IDLE and DONE.
- Read latency is 1 cycle. A write and a read to the same index in the same cycle returns the old value.

## Test plan
- **Basic iteration count:** N_POINTS=4, load x=y=i·1.0, model ec_new = centre + 1.0, `start` with num_iter=2.
  - `done` in cycle 13 and `busy` high in cycles 1–12.
  - Final pos0 = 0.0; pos1..3 = 0x00030000, 0x00040000, 0x00050000 in both x and y.
- **Gauss-Seidel ordering:** model ec_new = up, pos0 = 0x00050000, others 0, num_iter=1.
  - All of pos1..3 read back 0x00050000.
  - `ec_is_last` is high only while idx=3, and then ec_down = ec_centre.
- **Zero iterations:** num_iter=0 → `done` the cycle after `start`, `busy` never high, contents unchanged.
- **Ignored inputs while busy:** `wr_en` to idx 2 and a second `start` during a run are both ignored.
  - Contents match a run with neither event, and exactly one `done` pulse occurs.
- **Reset mid-run:** assert `rst_n`=0 mid-run (cycle 5) → all outputs 0 immediately and every `rd_idx` reads 0. A fresh `start` after release runs normally.
- **Read port:** N_POINTS=8. Write pos7 and read pos7 in the same cycle → `rd_x` shows the old value, then the new value one cycle later.
